// File: rtl/pc_unit.sv
// Fetch-stage PC register: next-PC select (reset > req > stall > jump > branch > seq), BD tracking, AdEL check.
// Latency: one cycle from D-stage control to F_PC; stall holds PC/BD, req overrides stall.
module pc_unit #(
  parameter int unsigned       PC_W       = 32,
  parameter logic [PC_W-1:0]   RESET_PC   = PC_W'(32'h0000_3000),
  parameter logic [PC_W-1:0]   HANDLER_PC = PC_W'(32'h0000_4180),
  parameter logic [PC_W-1:0]   IM_BASE    = PC_W'(32'h0000_3000),
  parameter logic [PC_W-1:0]   IM_LIMIT   = PC_W'(32'h0000_6FFC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            req,
  input  logic [PC_W-1:0] D_PC,
  input  logic [25:0]     instr_index_offset,
  input  logic [PC_W-1:0] regester,
  input  logic [PC_W-1:0] EPC,
  input  logic            branch,
  input  logic            condition,
  input  logic [1:0]      jump,
  output logic [PC_W-1:0] F_PC,
  output logic            F_BD,
  output logic [4:0]      F_excode,
  output logic            F_valid
);

  localparam logic [1:0] JMP_NONE = 2'd0;
  localparam logic [1:0] JMP_IDX  = 2'd1;
  localparam logic [1:0] JMP_REG  = 2'd2;
  localparam logic [1:0] JMP_EPC  = 2'd3;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            bd_q, bd_d;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] idx_target;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] br_disp;
  logic            illegal;

  assign seq_pc  = pc_q + PC_W'(4);
  assign br_disp = {{(PC_W-18){instr_index_offset[15]}}, instr_index_offset[15:0], 2'b00};
  assign br_target = D_PC + PC_W'(4) + br_disp;

  // Region bits above the 256 MB segment come from the D-stage PC.
  always_comb begin
    idx_target       = D_PC;
    idx_target[27:0] = {instr_index_offset, 2'b00};
  end

  always_comb begin
    pc_d = pc_q;
    bd_d = bd_q;
    if (req) begin
      pc_d = HANDLER_PC;
      bd_d = 1'b0;
    end else if (!stall) begin
      unique case (jump)
        JMP_IDX: begin
          pc_d = idx_target;
          bd_d = 1'b1;
        end
        JMP_REG: begin
          pc_d = regester;
          bd_d = 1'b1;
        end
        JMP_EPC: begin
          pc_d = EPC;
          bd_d = 1'b0;
        end
        JMP_NONE: begin
          pc_d = (branch && condition) ? br_target : seq_pc;
          bd_d = branch;
        end
        default: begin
          pc_d = seq_pc;
          bd_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      bd_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      bd_q <= bd_d;
    end
  end

  assign illegal  = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);
  assign F_PC     = pc_q;
  assign F_BD     = bd_q;
  assign F_excode = illegal ? 5'd4 : 5'd0;
  assign F_valid  = !illegal;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios then randomized D-stage control against an arithmetic reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, req, branch, condition;
  logic [31:0] D_PC, regester, EPC;
  logic [25:0] instr_index_offset;
  logic [1:0]  jump;
  logic [31:0] F_PC;
  logic        F_BD;
  logic [4:0]  F_excode;
  logic        F_valid;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_pc;
  logic        m_bd;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req),
    .D_PC(D_PC), .instr_index_offset(instr_index_offset),
    .regester(regester), .EPC(EPC), .branch(branch),
    .condition(condition), .jump(jump),
    .F_PC(F_PC), .F_BD(F_BD), .F_excode(F_excode), .F_valid(F_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] exp_excode(input logic [31:0] pc);
    if ((pc % 4) != 0 || pc < 32'h3000 || pc > 32'h6FFC) return 5'd4;
    return 5'd0;
  endfunction

  // Advance one edge; the model applies the priority rules to the inputs as driven.
  task automatic step(input string tag);
    logic [31:0] npc;
    logic        nbd;
    int          disp;
    npc = m_pc;
    nbd = m_bd;
    if (reset) begin
      npc = 32'h3000; nbd = 1'b0;
    end else if (req) begin
      npc = 32'h4180; nbd = 1'b0;
    end else if (!stall) begin
      case (jump)
        2'd1: begin npc = (D_PC & 32'hF000_0000) + ({6'd0, instr_index_offset} * 4); nbd = 1'b1; end
        2'd2: begin npc = regester; nbd = 1'b1; end
        2'd3: begin npc = EPC; nbd = 1'b0; end
        default: begin
          disp = int'($signed(instr_index_offset[15:0])) * 4;
          npc  = (branch && condition) ? D_PC + 32'd4 + 32'(disp) : m_pc + 32'd4;
          nbd  = branch;
        end
      endcase
    end
    @(posedge clk);
    m_pc = npc;
    m_bd = nbd;
    #1;
    chk({tag, ".pc"}, F_PC, m_pc);
    chk({tag, ".bd"}, {31'd0, F_BD}, {31'd0, m_bd});
    chk({tag, ".exc"}, {27'd0, F_excode}, {27'd0, exp_excode(m_pc)});
    chk({tag, ".vld"}, {31'd0, F_valid}, {31'd0, exp_excode(m_pc) == 5'd0});
  endtask

  task automatic idle();
    reset = 0; stall = 0; req = 0; branch = 0; condition = 0; jump = 2'd0;
  endtask

  initial begin
    m_pc = '0; m_bd = 1'b0;
    idle();
    D_PC = 32'h3000; instr_index_offset = '0; regester = '0; EPC = '0;
    reset = 1;
    step("rst");
    chk("rst_pc_const", F_PC, 32'h3000);
    idle();
    for (int i = 0; i < 3; i++) step("seq");
    chk("seq_300c", F_PC, 32'h300C);

    // taken then not-taken branch
    D_PC = 32'h3004; instr_index_offset = 26'h000FFFE; branch = 1; condition = 1;
    step("br_taken");
    chk("br_taken_const", F_PC, 32'h3000);
    condition = 0;
    step("br_nt");
    chk("br_nt_const", F_PC, 32'h3004);
    idle();

    // stalled index jump to 0x3100
    jump = 2'd1; instr_index_offset = 26'h0000C40; D_PC = 32'h3008; stall = 1;
    step("stall0");
    step("stall1");
    chk("stall_hold", F_PC, 32'h3004);
    stall = 0;
    step("jidx");
    chk("jidx_const", F_PC, 32'h3100);

    // req beats stall and jr, then eret
    stall = 1; req = 1; jump = 2'd2; regester = 32'h5000;
    step("req");
    chk("req_const", F_PC, 32'h4180);
    idle(); jump = 2'd3; EPC = 32'h3010;
    step("eret");
    chk("eret_const", F_PC, 32'h3010);

    // range / alignment boundaries via jr
    jump = 2'd2;
    regester = 32'h3002; step("mis");
    chk("mis_exc", {27'd0, F_excode}, 32'd4);
    regester = 32'h7000; step("hi");
    chk("hi_exc", {27'd0, F_excode}, 32'd4);
    regester = 32'h6FFC; step("lim");
    chk("lim_exc", {27'd0, F_excode}, 32'd0);
    regester = 32'h2FFC; step("lo");
    idle();
    step("ill_adv");

    // reset during stalled redirect
    stall = 1; jump = 2'd1; reset = 1;
    step("rst_mid");
    chk("rst_mid_const", F_PC, 32'h3000);
    idle();
    step("resume");
    chk("resume_const", F_PC, 32'h3004);

    // randomized control traffic
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(99) < 2);
      req       = ($urandom_range(99) < 5);
      stall     = ($urandom_range(99) < 20);
      jump      = 2'($urandom_range(3));
      branch    = $urandom_range(1);
      condition = $urandom_range(1);
      D_PC      = 32'h3000 + 32'($urandom_range(32'hFFF)) * 4;
      if ($urandom_range(9) == 0) D_PC = $urandom;
      instr_index_offset = 26'($urandom);
      regester  = ($urandom_range(3) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(32'h1000)) * 4;
      EPC       = 32'h3000 + 32'($urandom_range(32'hFFF)) * 4;
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Fetch-stage program-counter unit for the pipelined MIPS core. It generalises the combinational next-PC selector into a registered PC stage. It adds stall hold, exception entry, `eret` return, delay-slot (BD) tracking and fetch-address exception detection, with a parametrised PC width and address map. It sits at the head of F: its `F_PC` drives instruction memory, and its `F_BD`/`F_excode` travel down the pipeline with the fetched instruction.

## Interface
Parameters:
- `PC_W`, 32: PC width in bits; all address inputs and outputs are this wide.
- `RESET_PC`, 32'h0000_3000: PC loaded on reset.
- `HANDLER_PC`, 32'h0000_4180: exception/interrupt entry address.
- `IM_BASE`, 32'h0000_3000: lowest legal fetch address (inclusive).
- `IM_LIMIT`, 32'h0000_6FFC: highest legal fetch address (inclusive).

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard stall from the hazard unit: hold PC and BD.
- `req`  in  1  exception/interrupt request from CP0: redirect to `HANDLER_PC`.
- `D_PC`  in  PC_W  PC of the instruction currently in D.
- `instr_index_offset`  in  26  D-stage instr_index; bits [15:0] are the branch offset.
- `regester`  in  PC_W  forwarded rs value for jr/jalr.
- `EPC`  in  PC_W  return address from CP0.
- `branch`  in  1  D holds a conditional branch.
- `condition`  in  1  branch condition result, valid when `branch`=1.
- `jump`  in  2  0 none, 1 index (j/jal), 2 register (jr/jalr), 3 EPC (eret).
- `F_PC`  out  PC_W  current fetch address (registered).
- `F_BD`  out  1  fetched instruction is in a delay slot (registered).
- `F_excode`  out  5  5'd4 (AdEL) if `F_PC` is illegal, else 5'd0.
- `F_valid`  out  1  1 when `F_excode`==0; gates instruction-memory read.

## Operation
- The next-PC priority, highest first, is: `reset` > `req` > `stall` > `jump` > `branch` > sequential.
  - `reset`: PC<=RESET_PC, BD<=0.
  - `req`: PC<=HANDLER_PC, BD<=0. This applies even if `stall`=1 or a jump or branch is in D.
  - `stall`: PC and BD hold.
  - jump=1: PC<={D_PC[PC_W-1:28], instr_index, 2'b00}.
  - jump=2: PC<=regester.
  - jump=3: PC<=EPC. `eret` has no delay slot.
  - branch & condition: PC<=D_PC+4+(sext(offset)<<2).
  - branch & !condition, or no control: PC<=F_PC+4.
- BD update on an unstalled, non-req cycle:
  - BD<=1 when jump∈{1,2} or `branch`=1, regardless of `condition`.
  - BD<=0 when jump=3 or there is no control transfer.
- All adds are modulo 2^PC_W. Wrap past all-ones is not trapped here; it is caught by the range check.
- Register-jump targets are loaded unchanged, even if misaligned or out of range. The fault surfaces as AdEL when that PC is fetched.
- `F_excode`/`F_valid` are combinational from the PC register. The address is illegal if `F_PC[1:0]`!=0, `F_PC`<IM_BASE, or `F_PC`>IM_LIMIT.
- An illegal PC still advances normally. The unit does not self-redirect; exception entry comes only through `req`.
- `jump` values outside 0..3 cannot occur. The encoding is closed.

## Timing
- Reset values: `F_PC`=RESET_PC, `F_BD`=0, `F_excode`=0, `F_valid`=1, with the default map.
- Next-PC latency is one cycle. D-stage control in cycle n sets `F_PC` in cycle n+1.
- The delay slot is the instruction already in F when D resolves. It is not squashed by this unit.
- `req` wins over everything except `reset`. A `req` during a `stall` redirects in the same edge.
- `reset` in the middle of a stall or redirect discards all pending state on that edge.
- `stall` held for k cycles keeps `F_PC`/`F_BD` constant for k edges. The redirect takes effect on the first unstalled edge, provided D inputs are still presented.
- `F_excode` changes in the same cycle as `F_PC`. There is no added latency.

## Test plan
- Reset, then 3 free-running cycles → `F_PC` = 0x3000, 0x3004, 0x3008, 0x300C; `F_BD`=0 throughout.
- Taken branch with D_PC=0x3004, offset=0xFFFE → next `F_PC`=0x3000, `F_BD`=1. Not-taken with the same setup → `F_PC`=F_PC+4, `F_BD`=1.
- `stall` for 2 cycles with a `jump`=1 to 0x3100 held in D → `F_PC` unchanged for 2 edges, then 0x3100 with `F_BD`=1.
- `req` asserted together with `stall` and `jump`=2 → next `F_PC`=0x4180, `F_BD`=0. Then `jump`=3 with EPC=0x3010 → `F_PC`=0x3010, `F_BD`=0.
- `jump`=2 with regester=0x3002 → `F_excode`=4, `F_valid`=0. With regester=0x7000 → `F_excode`=4. With 0x6FFC → `F_excode`=0.
- `reset` asserted during a stalled redirect → `F_PC`=0x3000, `F_BD`=0 on that edge; the normal sequence resumes the following cycle.
